// File: rtl/rat_walker.sv
// rat_walker: undoes speculative RAT mappings, youngest squashed ROB entry first.
// Define RAT_WALKER_STALL_EN to add the rat_walker_stall freeze input.
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 6
`endif

module rat_walker (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit_walker_flush_req,
  input  logic [`ROB_ID_WIDTH-1:0]     commit_walker_flush_tail_id,
  input  logic [`ROB_ID_WIDTH:0]       commit_walker_flush_num,
  output logic [`ROB_ID_WIDTH-1:0]     walker_rob_read_id,
  input  logic                         rob_walker_rd_valid,
  input  logic [`PHY_REG_ID_WIDTH-1:0] rob_walker_new_phy_id,
  input  logic [`PHY_REG_ID_WIDTH-1:0] rob_walker_old_phy_id,
  output logic [`PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_phy_id,
  output logic [`PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_phy_id,
  output logic                         commit_rat_restore_map,
`ifdef RAT_WALKER_STALL_EN
  input  logic                         rat_walker_stall,
`endif
  output logic                         walker_commit_busy,
  output logic                         walker_commit_done
);

  localparam int IW = `ROB_ID_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(`ROB_SIZE - 1);
  localparam logic [IW:0]   ONE  = (IW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   cur_q;
  logic [IW:0]     remain_q;
  logic            stall;
  logic            in_walk;
  logic            step;
  logic [IW-1:0]   tail_m1;
  logic [IW-1:0]   cur_m1;

`ifdef RAT_WALKER_STALL_EN
  assign stall = rat_walker_stall;
`else
  assign stall = 1'b0;
`endif

  assign in_walk = (state_q == WALK) && !rst;
  assign step    = in_walk && !stall;

  // Both slot decrements wrap explicitly so non power-of-two ROBs work.
  assign tail_m1 = (commit_walker_flush_tail_id == '0) ? LAST
                 : commit_walker_flush_tail_id - 1'b1;
  assign cur_m1  = (cur_q == '0) ? LAST : cur_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      remain_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (commit_walker_flush_req) begin
            cur_q    <= tail_m1;
            remain_q <= commit_walker_flush_num;
            state_q  <= (commit_walker_flush_num == '0) ? DONE : WALK;
          end
        end
        WALK: begin
          if (!stall) begin
            cur_q    <= cur_m1;
            remain_q <= remain_q - 1'b1;
            if (remain_q <= ONE) state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign walker_rob_read_id     = in_walk ? cur_q : '0;
  assign commit_rat_restore_map = step && rob_walker_rd_valid;

  assign commit_rat_restore_new_phy_id =
    commit_rat_restore_map ? rob_walker_new_phy_id : '0;
  assign commit_rat_restore_old_phy_id =
    commit_rat_restore_map ? rob_walker_old_phy_id : '0;

  assign walker_commit_busy = !rst && (state_q != IDLE);
  assign walker_commit_done = !rst && (state_q == DONE);

endmodule

// File: tb/tb_rat_walker.sv
// tb_rat_walker: queue-based walk model compared every cycle, plus
// hand-computed literal checks per scenario.
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 6
`endif

module tb_rat_walker;
  localparam int IW = `ROB_ID_WIDTH;
  localparam int PW = `PHY_REG_ID_WIDTH;
  localparam int RS = `ROB_SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req;
  logic [IW-1:0] tail;
  logic [IW:0]   num;
  logic [IW-1:0] read_id;
  logic          rd_valid;
  logic [PW-1:0] new_id, old_id;
  logic [PW-1:0] r_new, r_old;
  logic          r_map;
  logic          stall;
  logic          busy, done;

  logic          rob_v   [RS];
  logic [PW-1:0] rob_new [RS];
  logic [PW-1:0] rob_old [RS];

  assign rd_valid = rob_v[read_id];
  assign new_id   = rob_new[read_id];
  assign old_id   = rob_old[read_id];

  rat_walker dut (
    .clk                           (clk),
    .rst                           (rst),
    .commit_walker_flush_req       (flush_req),
    .commit_walker_flush_tail_id   (tail),
    .commit_walker_flush_num       (num),
    .walker_rob_read_id            (read_id),
    .rob_walker_rd_valid           (rd_valid),
    .rob_walker_new_phy_id         (new_id),
    .rob_walker_old_phy_id         (old_id),
    .commit_rat_restore_new_phy_id (r_new),
    .commit_rat_restore_old_phy_id (r_old),
    .commit_rat_restore_map        (r_map),
`ifdef RAT_WALKER_STALL_EN
    .rat_walker_stall              (stall),
`endif
    .walker_commit_busy            (busy),
    .walker_commit_done            (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected schedule: one entry per remaining busy cycle; walk=0 is DONE.
  typedef struct {
    bit            walk;
    logic [IW-1:0] id;
  } ent_t;
  ent_t q[$];

  int idlog[$];
  int maplog[$];
  int strobes, busy_n, done_n, done_at;

  always @(negedge clk) begin
    logic [2*PW+IW+2:0] exp, got;
    logic m;
    m = 1'b0;
    if (rst || q.size() == 0) begin
      exp = '0;
    end else if (!q[0].walk) begin
      exp = {1'b1, 1'b1, {IW{1'b0}}, 1'b0, {PW{1'b0}}, {PW{1'b0}}};
    end else begin
      m   = !stall && rob_v[q[0].id];
      exp = {1'b1, 1'b0, q[0].id, m,
             m ? rob_new[q[0].id] : {PW{1'b0}},
             m ? rob_old[q[0].id] : {PW{1'b0}}};
    end
    got = {busy, done, read_id, r_map, r_new, r_old};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cycle t=%0t outputs got %h expected %h", $time, got, exp);
    end
    if (!rst) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = busy_n;
      end
      if (busy && !done) begin
        idlog.push_back(int'(read_id));
        maplog.push_back(int'(r_map));
      end
      if (r_map) strobes++;
    end
    if (rst) begin
      q.delete();
    end else if (q.size() != 0) begin
      if (!(q[0].walk && stall)) void'(q.pop_front());
    end else if (flush_req) begin
      for (int k = 0; k < int'(num); k++)
        q.push_back('{1'b1, IW'((int'(tail) + RS - 1 - k) % RS)});
      q.push_back('{1'b0, '0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clear_logs();
    idlog.delete();
    maplog.delete();
    strobes = 0;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
  endtask

  function automatic int pack_ids(input int n);
    int v;
    v = 0;
    for (int i = 0; i < n; i++)
      v = v * 16 + ((i < idlog.size()) ? idlog[i] : 0);
    return v;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL timeout: busy got 1 expected 0");
    end
  endtask

  task automatic run(input int t, input int n);
    clear_logs();
    tail      = IW'(t);
    num       = (IW+1)'(n);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst       = 1'b1;
    flush_req = 1'b0;
    stall     = 1'b0;
    tail      = '0;
    num       = '0;
    for (int i = 0; i < RS; i++) begin
      rob_v[i]   = 1'b1;
      rob_new[i] = PW'(i + 32);
      rob_old[i] = PW'(i + 1);
    end
    clear_logs();
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_read_id", int'(read_id), 0);
    rst = 1'b0;
    tick();

    run(5, 3);
    check("basic_ids", pack_ids(3), 'h432);
    check("basic_nids", idlog.size(), 3);
    check("basic_strobes", strobes, 3);
    check("basic_busy", busy_n, 4);
    check("basic_done_at", done_at, 4);

    run(1, 4);
    check("wrap_ids", pack_ids(4), 'h0fed);
    check("wrap_done", done_n, 1);

    run(7, 0);
    check("zero_strobes", strobes, 0);
    check("zero_busy", busy_n, 1);
    check("zero_done", done_n, 1);

    run(0, 16);
    check("full_nids", idlog.size(), 16);
    check("full_first", pack_ids(1), 15);
    check("full_last", idlog[15], 0);
    check("full_busy", busy_n, 17);

    rob_v[3] = 1'b0;
    run(5, 3);
    check("gap_map_pat",
          maplog[0] * 4 + maplog[1] * 2 + maplog[2], 5);
    check("gap_strobes", strobes, 2);
    check("gap_busy", busy_n, 4);
    rob_v[3] = 1'b1;

    clear_logs();
    tail      = 4'd5;
    num       = 5'd3;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy_now", int'(busy), 0);
    check("rst_read_id", int'(read_id), 0);
    check("rst_done", done_n, 0);
    check("rst_busy_cycles", busy_n, 1);
    run(3, 2);
    check("rst_new_ids", pack_ids(2), 'h21);
    check("rst_new_done", done_n, 1);

`ifdef RAT_WALKER_STALL_EN
    clear_logs();
    tail      = 4'd10;
    num       = 5'd4;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    stall     = 1'b1;
    flush_req = 1'b1;
    tail      = 4'd0;
    num       = 5'd5;
    tick();
    tick();
    stall     = 1'b0;
    flush_req = 1'b0;
    wait_idle();
    check("stall_ids", pack_ids(6), 'h988876);
    check("stall_strobes", strobes, 4);
    check("stall_busy", busy_n, 7);
    check("stall_done", done_n, 1);
    tick();
    check("stall_ignored", int'(busy), 0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rat_walker.md
RAT_WALKER -- requirements
Module: rat_walker

Interface
REQ-001 SHALL expose: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL expose: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL expose: commit_walker_flush_req  input  1  start a recovery walk; sampled only in IDLE.
REQ-004 SHALL expose: commit_walker_flush_tail_id  input  `ROB_ID_WIDTH  ROB slot one past the youngest squashed entry.
REQ-005 SHALL expose: commit_walker_flush_num  input  `ROB_ID_WIDTH+1  number of squashed entries; 0 up to `ROB_SIZE.
REQ-006 SHALL expose: walker_rob_read_id  output  `ROB_ID_WIDTH  ROB slot being read; combinational read, data returned same cycle.
REQ-007 SHALL expose: rob_walker_rd_valid  input  1  the entry read allocated a destination register.
REQ-008 SHALL expose: rob_walker_new_phy_id / rob_walker_old_phy_id  input  `PHY_REG_ID_WIDTH each  new and previous mapping of the entry read.
REQ-009 SHALL expose: commit_rat_restore_new_phy_id / commit_rat_restore_old_phy_id  output  `PHY_REG_ID_WIDTH each  mapping to undo in the RAT.
REQ-010 SHALL expose: commit_rat_restore_map  output  1  RAT restore strobe, one mapping per cycle.
REQ-011 SHALL expose: walker_commit_busy  output  1  high in WALK and DONE.
REQ-012 SHALL expose: walker_commit_done  output  1  one-cycle pulse when the walk completes.
REQ-013 SHALL expose, when RAT_WALKER_STALL_EN is defined: rat_walker_stall  input  1  freeze the walk for this cycle.

Function
REQ-014 SHALL implement FSM states IDLE, WALK and DONE.
REQ-015 SHALL, in IDLE with flush_req=1, latch cur=tail_id-1 (mod `ROB_SIZE) and remain=flush_num, then enter WALK; if flush_num=0, enter DONE directly.
REQ-016 SHALL drive walker_rob_read_id=cur in WALK and 0 otherwise.
REQ-017 SHALL, in each unstalled WALK cycle with rd_valid=1, assert commit_rat_restore_map=1 with restore_new_phy_id=rob_walker_new_phy_id and restore_old_phy_id=rob_walker_old_phy_id, combinationally in that cycle.
REQ-018 SHALL, in WALK with rd_valid=0, hold restore_map=0 and still advance.
REQ-019 SHALL, on each unstalled WALK cycle, decrement cur with wrap from 0 to `ROB_SIZE-1 and decrement remain; when remain reaches 1, go to DONE on the next edge.
REQ-020 SHALL process entries strictly youngest to oldest, exactly flush_num entries, at one entry per cycle (walk latency = flush_num cycles + 1 DONE cycle).
REQ-021 SHALL, in DONE, pulse walker_commit_done=1 for one cycle and return to IDLE.
REQ-022 SHALL ignore flush_req while in WALK or DONE.
REQ-023 SHALL accept flush_req in the cycle immediately after DONE.
REQ-024 SHALL hold restore outputs at 0 whenever restore_map=0.

Reset
REQ-025 SHALL, on rst=1, force IDLE, cur=0 and remain=0, including mid-walk, with the walk abandoned.
REQ-026 SHALL reset all outputs to 0: restore_map, restore_new/old_phy_id, busy, done and rob_read_id.
REQ-027 SHALL give rst priority over flush_req and stall.

Configuration
REQ-028 SHALL, with RAT_WALKER_STALL_EN defined, provide rat_walker_stall; stall=1 in WALK holds cur and remain and forces restore_map=0, with no effect in IDLE or DONE.
REQ-029 SHALL, with RAT_WALKER_STALL_EN undefined, omit the stall port and never stall.

Verification (`ROB_SIZE=16)
REQ-030 SHALL verify a basic walk: tail=5, num=3, all rd_valid=1 -> reads of ids 4, 3, 2 on consecutive cycles; three restore strobes in that order; done pulse in cycle 4; busy high for 4 cycles.
REQ-031 SHALL verify wrap-around: tail=1, num=4 -> read ids 0, 15, 14, 13.
REQ-032 SHALL verify zero and full walks: num=0 -> no strobes, done one cycle after request; num=16, tail=0 -> 16 reads 15..0, then done.
REQ-033 SHALL verify gaps: rd_valid pattern 1,0,1 -> restore_map pattern 1,0,1 and walk length still 3.
REQ-034 SHALL verify reset mid-walk: rst in the second WALK cycle -> next cycle IDLE with all outputs 0, no done pulse, and a new flush accepted.
REQ-035 SHALL verify stall (RAT_WALKER_STALL_EN defined): stall=1 for 2 cycles mid-walk -> read id held, no strobes, walk completes 2 cycles later, and a flush_req during busy is ignored.
